// File: rtl/xgmii_tx_arbiter.sv
// xgmii_tx_arbiter: round-robin frame scheduler feeding one XGMII SDR transmit
// interface (64-bit TXD / 8-bit TXC). Whole frames are granted; the block adds
// the start/preamble word, the terminate character and idle words so that the
// minimum inter-frame gap (counted from /T/ inclusive to the next /S/) is met.
//
// The state register describes what the *next* XGMII word will be built from.
// The preamble is emitted on the arbitration edge itself (leaving IDLE), so
// the granted source can already hand over its first word one edge later.
// GRANT stays visible until the word carrying /T/ is on the wire.
module xgmii_tx_arbiter #(
  parameter int PORTS     = 2,
  parameter int IFG_BYTES = 12
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [PORTS*64-1:0]  rx_data_i,
  input  logic [PORTS-1:0]     rx_sop_i,
  input  logic [PORTS-1:0]     rx_eop_i,
  input  logic [PORTS*3-1:0]   rx_eop_pos_i,
  input  logic [PORTS-1:0]     rx_src_rdy_i,
  output logic [PORTS-1:0]     rx_dst_rdy_o,
  output logic [63:0]          xgmii_txd_o,
  output logic [7:0]           xgmii_txc_o,
  output logic [PORTS-1:0]     grant_o,
  output logic                 underrun_o,
  output logic                 drop_o
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  // Next-word source: IDLE arbitrates, DATA forwards, TERM sends a lone /T/,
  // IFG pads with idle words.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_TERM = 3'd2;
  localparam logic [2:0] ST_IFG  = 3'd3;

  localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;
  localparam logic [63:0] PRE_WORD  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_WORD = 64'h07070707070707FD;
  localparam logic [63:0] ERR_WORD  = 64'hFEFEFEFEFEFEFEFE;

  // Idle words still needed after a terminate that left 'trail' bytes of gap.
  function automatic logic [7:0] ifg_words(input int trail);
    int rem;
    rem = IFG_BYTES - trail;
    if (rem > 0) begin
      return 8'((rem + 7) / 8);
    end else begin
      return 8'd0;
    end
  endfunction

  // Build {TXC, TXD} for an EOP word whose last valid byte is lane 'pos' (<7).
  function automatic logic [71:0] eop_word(input logic [63:0] data, input logic [2:0] pos);
    logic [63:0] d;
    logic [7:0]  c;
    d = 64'd0;
    c = 8'd0;
    for (int k = 0; k < 8; k++) begin
      if (k <= int'(pos)) begin
        d[8*k +: 8] = data[8*k +: 8];
        c[k]        = 1'b0;
      end else if (k == int'(pos) + 1) begin
        d[8*k +: 8] = 8'hFD;
        c[k]        = 1'b1;
      end else begin
        d[8*k +: 8] = 8'h07;
        c[k]        = 1'b1;
      end
    end
    return {c, d};
  endfunction

  logic [2:0]       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [7:0]       ifg_cnt_q, ifg_cnt_d;
  logic [63:0]      txd_q, txd_d;
  logic [7:0]       txc_q, txc_d;
  logic             underrun_q, underrun_d;
  logic             drop_q, drop_d;

  logic [PORTS-1:0] elig_s;
  logic [PORTS-1:0] stray_s;
  logic [PORTS-1:0] win_oh_s;
  logic             win_valid_s;
  logic [PW-1:0]    win_next_ptr_s;
  logic [PORTS-1:0] stray_oh_s;
  logic             stray_valid_s;
  logic [63:0]      sel_data_s;
  logic             sel_eop_s;
  logic [2:0]       sel_pos_s;
  logic             sel_rdy_s;
  logic [PORTS-1:0] dst_rdy_s;
  logic [7:0]       cnt_s;

  assign elig_s  = rx_src_rdy_i & rx_sop_i;
  assign stray_s = rx_src_rdy_i & ~rx_sop_i;

  // Round-robin pick: first eligible port at or after the pointer, then wrap.
  always_comb begin
    win_valid_s    = 1'b0;
    win_oh_s       = '0;
    win_next_ptr_s = ptr_q;
    for (int j = 0; j < PORTS; j++) begin
      if (!win_valid_s && elig_s[j] && (j >= int'(ptr_q))) begin
        win_valid_s    = 1'b1;
        win_oh_s[j]    = 1'b1;
        win_next_ptr_s = (j == PORTS - 1) ? '0 : PW'(j + 1);
      end else begin
        win_valid_s = win_valid_s;
      end
    end
    for (int j = 0; j < PORTS; j++) begin
      if (!win_valid_s && elig_s[j] && (j < int'(ptr_q))) begin
        win_valid_s    = 1'b1;
        win_oh_s[j]    = 1'b1;
        win_next_ptr_s = (j == PORTS - 1) ? '0 : PW'(j + 1);
      end else begin
        win_valid_s = win_valid_s;
      end
    end
  end

  // Lowest-indexed port offering a non-SOP word while no frame is open.
  always_comb begin
    stray_valid_s = 1'b0;
    stray_oh_s    = '0;
    for (int j = 0; j < PORTS; j++) begin
      if (!stray_valid_s && stray_s[j]) begin
        stray_valid_s = 1'b1;
        stray_oh_s[j] = 1'b1;
      end else begin
        stray_valid_s = stray_valid_s;
      end
    end
  end

  // Select the granted port's word and sideband signals.
  always_comb begin
    sel_data_s = 64'd0;
    sel_eop_s  = 1'b0;
    sel_pos_s  = 3'd0;
    sel_rdy_s  = 1'b0;
    for (int j = 0; j < PORTS; j++) begin
      if (grant_q[j]) begin
        sel_data_s = sel_data_s | rx_data_i[64*j +: 64];
        sel_eop_s  = sel_eop_s | rx_eop_i[j];
        sel_pos_s  = sel_pos_s | rx_eop_pos_i[3*j +: 3];
        sel_rdy_s  = sel_rdy_s | rx_src_rdy_i[j];
      end else begin
        sel_rdy_s = sel_rdy_s;
      end
    end
  end

  // Next-state, handshake and next XGMII word.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    ifg_cnt_d  = ifg_cnt_q;
    txd_d      = IDLE_WORD;
    txc_d      = 8'hFF;
    underrun_d = 1'b0;
    drop_d     = 1'b0;
    dst_rdy_s  = '0;
    cnt_s      = 8'd0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (win_valid_s) begin
          grant_d = win_oh_s;
          ptr_d   = win_next_ptr_s;
          txd_d   = PRE_WORD;
          txc_d   = 8'h01;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
        if (stray_valid_s) begin
          dst_rdy_s = stray_oh_s;
          drop_d    = 1'b1;
        end else begin
          drop_d = 1'b0;
        end
      end
      ST_DATA: begin
        dst_rdy_s = grant_q;
        if (!sel_rdy_s) begin
          txd_d      = ERR_WORD;
          txc_d      = 8'hFF;
          underrun_d = 1'b1;
        end else if (!sel_eop_s) begin
          txd_d = sel_data_s;
          txc_d = 8'h00;
        end else if (sel_pos_s == 3'd7) begin
          txd_d   = sel_data_s;
          txc_d   = 8'h00;
          state_d = ST_TERM;
        end else begin
          {txc_d, txd_d} = eop_word(sel_data_s, sel_pos_s);
          cnt_s          = ifg_words(7 - int'(sel_pos_s));
          ifg_cnt_d      = cnt_s;
          state_d        = (cnt_s == 8'd0) ? ST_IDLE : ST_IFG;
        end
      end
      ST_TERM: begin
        txd_d     = TERM_WORD;
        txc_d     = 8'hFF;
        cnt_s     = ifg_words(8);
        ifg_cnt_d = cnt_s;
        state_d   = (cnt_s == 8'd0) ? ST_IDLE : ST_IFG;
      end
      ST_IFG: begin
        grant_d = '0;
        if (ifg_cnt_q <= 8'd1) begin
          ifg_cnt_d = 8'd0;
          state_d   = ST_IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q - 8'd1;
          state_d   = ST_IFG;
        end
        if (stray_valid_s) begin
          dst_rdy_s = stray_oh_s;
          drop_d    = 1'b1;
        end else begin
          drop_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        ifg_cnt_d = 8'd0;
      end
    endcase
  end

  // State, arbitration pointer and registered XGMII outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      ifg_cnt_q  <= 8'd0;
      txd_q      <= IDLE_WORD;
      txc_q      <= 8'hFF;
      underrun_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      ifg_cnt_q  <= ifg_cnt_d;
      txd_q      <= txd_d;
      txc_q      <= txc_d;
      underrun_q <= underrun_d;
      drop_q     <= drop_d;
    end
  end

  assign rx_dst_rdy_o = dst_rdy_s;
  assign grant_o      = grant_q;
  assign xgmii_txd_o  = txd_q;
  assign xgmii_txc_o  = txc_q;
  assign underrun_o   = underrun_q;
  assign drop_o       = drop_q;

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// Directed bench for xgmii_tx_arbiter (PORTS=2, IFG_BYTES=12).
module tb_xgmii_tx_arbiter;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W = 64'h07070707070707FD;
  localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;

  logic         clk;
  logic         rst_n;
  logic [127:0] rx_data;
  logic [1:0]   rx_sop;
  logic [1:0]   rx_eop;
  logic [5:0]   rx_eop_pos;
  logic [1:0]   rx_src_rdy;
  logic [1:0]   rx_dst_rdy;
  logic [63:0]  txd;
  logic [7:0]   txc;
  logic [1:0]   grant;
  logic         underrun;
  logic         drop;

  int checks;
  int failures;

  xgmii_tx_arbiter #(.PORTS(2), .IFG_BYTES(12)) dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .rx_data_i    (rx_data),
    .rx_sop_i     (rx_sop),
    .rx_eop_i     (rx_eop),
    .rx_eop_pos_i (rx_eop_pos),
    .rx_src_rdy_i (rx_src_rdy),
    .rx_dst_rdy_o (rx_dst_rdy),
    .xgmii_txd_o  (txd),
    .xgmii_txc_o  (txc),
    .grant_o      (grant),
    .underrun_o   (underrun),
    .drop_o       (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every registered output at once: grant, underrun, drop, txc, txd.
  task automatic chk_out(input string tag, input logic [63:0] e_txd, input logic [7:0] e_txc,
                         input logic [1:0] e_gnt, input logic e_und, input logic e_drop);
    chk(tag, {4'd0, grant, underrun, drop, txc, txd}, {4'd0, e_gnt, e_und, e_drop, e_txc, e_txd});
  endtask

  task automatic drive(input int p, input logic rdy, input logic sop, input logic eop,
                       input logic [2:0] pos, input logic [63:0] d);
    rx_src_rdy[p]         = rdy;
    rx_sop[p]             = sop;
    rx_eop[p]             = eop;
    rx_eop_pos[3*p +: 3]  = pos;
    rx_data[64*p +: 64]   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          cnt [2];
  int          fr  [2];
  logic [1:0]  acc;
  int          q;
  int          f;
  int          pp;
  logic [63:0] ew;

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    rx_data    = '0;
    rx_sop     = '0;
    rx_eop     = '0;
    rx_eop_pos = '0;
    rx_src_rdy = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_out("reset_out", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);
    chk("reset_dst", {78'd0, rx_dst_rdy}, 80'd0);
    rst_n = 1'b1;
    tick();
    chk_out("idle_after_reset", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);

    // Port 0, 16-byte frame ending at lane 7
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'h0102030405060708);
    #1;
    chk("f1_dst_idle", {78'd0, rx_dst_rdy}, 80'd0);
    tick();
    chk_out("f1_pre", PRE_W, 8'h01, 2'b01, 1'b0, 1'b0);
    chk("f1_dst_data", {78'd0, rx_dst_rdy}, 80'd1);
    tick();
    chk_out("f1_w0", 64'h0102030405060708, 8'h00, 2'b01, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd7, 64'h1112131415161718);
    tick();
    chk_out("f1_w1", 64'h1112131415161718, 8'h00, 2'b01, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
    #1;
    chk("f1_dst_term", {78'd0, rx_dst_rdy}, 80'd0);
    tick();
    chk_out("f1_term", TERM_W, 8'hFF, 2'b01, 1'b0, 1'b0);
    tick();
    chk_out("f1_ifg", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);
    tick();
    chk_out("f1_idle", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);

    // Port 1, 13-byte frame ending at lane 4; port 0 waits behind it
    drive(1, 1'b1, 1'b1, 1'b0, 3'd0, 64'hA1A2A3A4A5A6A7A8);
    tick();
    chk_out("f2_pre", PRE_W, 8'h01, 2'b10, 1'b0, 1'b0);
    tick();
    chk_out("f2_w0", 64'hA1A2A3A4A5A6A7A8, 8'h00, 2'b10, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b1, 3'd4, 64'h1122334455667788);
    tick();
    chk_out("f2_eop_p4", {8'h07, 8'h07, 8'hFD, 40'h4455667788}, 8'hE0, 2'b10, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'hC1C2C3C4C5C6C7C8);
    tick();
    chk_out("f2_ifg1", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);
    tick();
    chk_out("f2_ifg2", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);
    tick();
    chk_out("f3_pre", PRE_W, 8'h01, 2'b01, 1'b0, 1'b0);

    // Port 0 frame with a two-cycle source stall
    tick();
    chk_out("f3_w0", 64'hC1C2C3C4C5C6C7C8, 8'h00, 2'b01, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
    tick();
    chk_out("f3_und1", ERR_W, 8'hFF, 2'b01, 1'b1, 1'b0);
    tick();
    chk_out("f3_und2", ERR_W, 8'hFF, 2'b01, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd7, 64'hD1D2D3D4D5D6D7D8);
    tick();
    chk_out("f3_w1", 64'hD1D2D3D4D5D6D7D8, 8'h00, 2'b01, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
    tick();
    chk_out("f3_term", TERM_W, 8'hFF, 2'b01, 1'b0, 1'b0);
    tick();
    chk_out("f3_ifg", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);

    // Stray non-SOP word on port 1 while idle, then a one-word frame
    drive(1, 1'b1, 1'b0, 1'b0, 3'd0, 64'h5555AAAA5555AAAA);
    #1;
    chk("stray_dst", {78'd0, rx_dst_rdy}, 80'd2);
    tick();
    chk_out("stray_drop", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
    #1;
    chk("stray_dst_off", {78'd0, rx_dst_rdy}, 80'd0);
    tick();
    chk_out("stray_after", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b1, 1'b1, 3'd0, 64'hAABBCCDDEEFF0011);
    tick();
    chk_out("f4_pre", PRE_W, 8'h01, 2'b10, 1'b0, 1'b0);
    tick();
    chk_out("f4_eop_p0", {48'h070707070707, 8'hFD, 8'h11}, 8'hFE, 2'b10, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
    tick();
    chk_out("f4_ifg", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);
    tick();
    chk_out("f4_idle", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);

    // Both ports continuously offering 8-word frames (last word lane 7)
    for (int p = 0; p < 2; p++) begin
      cnt[p] = 0;
      fr[p]  = 0;
      drive(p, 1'b1, 1'b1, 1'b0, 3'd7, {8'(p), 8'(0), 8'(0), 40'h0123456789});
    end
    #1;
    acc = rx_dst_rdy;
    for (int i = 0; i < 36; i++) begin
      tick();
      q  = i % 11;
      f  = i / 11;
      pp = f % 2;
      if (q == 0) begin
        chk_out("b2b_pre", PRE_W, 8'h01, 2'(1 << pp), 1'b0, 1'b0);
      end else if (q <= 8) begin
        ew = {8'(pp), 8'(f / 2), 8'(q - 1), 40'h0123456789};
        chk_out("b2b_data", ew, 8'h00, 2'(1 << pp), 1'b0, 1'b0);
      end else if (q == 9) begin
        chk_out("b2b_term", TERM_W, 8'hFF, 2'(1 << pp), 1'b0, 1'b0);
      end else begin
        chk_out("b2b_ifg", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);
      end
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          if (cnt[p] == 7) begin
            cnt[p] = 0;
            fr[p]  = fr[p] + 1;
          end else begin
            cnt[p] = cnt[p] + 1;
          end
        end
        drive(p, 1'b1, (cnt[p] == 0), (cnt[p] == 7), 3'd7,
              {8'(p), 8'(fr[p]), 8'(cnt[p]), 40'h0123456789});
      end
      #1;
      acc = rx_dst_rdy;
    end

    // Reset for one cycle in the middle of port 1's frame
    drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'hE1E2E3E4E5E6E7E8);
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid_out", IDLE_W, 8'hFF, 2'b00, 1'b0, 1'b0);
    chk("rst_mid_dst", {78'd0, rx_dst_rdy}, 80'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    chk_out("rst_rel_pre", PRE_W, 8'h01, 2'b01, 1'b0, 1'b0);
    tick();
    chk_out("rst_rel_w0", 64'hE1E2E3E4E5E6E7E8, 8'h00, 2'b01, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xgmii_tx_arbiter.md
# xgmii_tx_arbiter

Round-robin scheduler that shares one XGMII SDR transmit interface (64-bit TXD / 8-bit TXC) between PORTS frame sources. It grants whole frames, inserts the start/preamble word, terminate and idle control characters, and enforces the minimum inter-frame gap. It sits between the per-channel TX frame buffers and the XGMII SDR/DDR output stage.

## Interface

- PORTS, 2, number of requesting frame sources (2..8)
- IFG_BYTES, 12, minimum gap in bytes, counted from /T/ inclusive to the next /S/

- CLK  in  1  system clock; all logic rising-edge
- RESET_N  in  1  asynchronous, active-low reset
- RX_DATA  in  PORTS*64  frame word per port, byte lane k = bits 8k+7:8k, lane 0 first on wire
- RX_SOP  in  PORTS  word is first of frame
- RX_EOP  in  PORTS  word is last of frame
- RX_EOP_POS  in  PORTS*3  index of last valid byte in EOP word (0..7)
- RX_SRC_RDY  in  PORTS  word valid
- RX_DST_RDY  out  PORTS  word accepted when SRC_RDY & DST_RDY
- XGMII_TXD  out  64  registered XGMII data
- XGMII_TXC  out  8  registered XGMII control, bit k = lane k
- GRANT  out  PORTS  one-hot port owning the current frame, 0 when none
- UNDERRUN  out  1  one-cycle pulse per error word emitted
- DROP  out  1  one-cycle pulse per stray non-SOP word discarded

## Operation

- States: IDLE, PREAMBLE, DATA, TERM, IFG.
- Arbitration point: IDLE, or IFG on its last cycle. Eligible port: RX_SRC_RDY & RX_SOP. Winner = first eligible port after last winner (round robin pointer, reset 0, so port 0 first). Winner latched into GRANT until its frame's terminate is sent.
- PREAMBLE: emit TXD = D5 55 55 55 55 55 55 FB (lane 7..0), TXC = 0x01. RX_DST_RDY all 0.
- DATA: RX_DST_RDY[grant] = 1, others 0. Accepted non-EOP word -> TXD = RX_DATA, TXC = 0x00. RX_SOP on granted port mid-frame is ignored (word is data).
- EOP word with pos p<7: lanes 0..p data, lane p+1 = FD, lanes above = 07; TXC bits p+1..7 set (p=4 -> 0xE0). Go to IFG.
- EOP word with p=7: full data word, TXC=0x00, then TERM: TXD = 07×7, FD in lane 0, TXC = 0xFF.
- Underrun: in DATA with RX_SRC_RDY[grant]=0 -> emit TXD = FE×8, TXC = 0xFF, pulse UNDERRUN; stay in DATA, frame continues when data resumes.
- IFG: emit idle words (TXD = 07×8, TXC = 0xFF). Trailing bytes t = 7-p for the EOP cycle, t = 8 for TERM. Idle word count = ceil((IFG_BYTES - t)/8), minimum 0; with IFG_BYTES=12: p=0..3 -> 1, p=4..6 -> 2, TERM -> 1. If count is 0, arbitration happens in the terminate cycle.
- Stray word: in IDLE/IFG, a port with SRC_RDY & !SOP gets DST_RDY=1, word discarded, DROP pulses (one per word; lowest-indexed such port per cycle).
- No grant available: stay IDLE emitting idle words.

## Timing

- Reset (async, immediate): XGMII_TXD = 0x0707070707070707, XGMII_TXC = 0xFF, RX_DST_RDY = 0, GRANT = 0, UNDERRUN = DROP = 0, state IDLE, pointer 0. Reset mid-frame abandons the frame without /T/; no recovery action.
- RX_DST_RDY, GRANT: combinational from registered state; no combinational path from RX_SRC_RDY to RX_DST_RDY of the same port except the stray-drop case.
- Request seen at edge n -> preamble word on XGMII after edge n; first data word accepted at edge n+1, visible after edge n+1. Data latency accept -> XGMII: 1 cycle.
- Back-to-back: next preamble directly follows the last IFG word, no extra idle.
- Throughput: one word per cycle; overhead per frame = 1 preamble + IFG words (+1 TERM if p=7).

## Test plan

- Port 0, 16-byte frame (2 words, EOP p=7): preamble (TXC 0x01), 2 data words TXC 0x00, TERM FD+07 TXC 0xFF, 1 idle word, then idle forever; GRANT=0b01 from preamble through TERM.
- Port 1, 13-byte frame (EOP p=4): data word 2 has lanes 0..4 data, lane 5 FD, lanes 6-7 07, TXC 0xE0; exactly 2 idle words before any next preamble.
- Both ports continuously offering 64-byte frames: grants alternate 0,1,0,1; each gap exactly 1 idle word (p=7 -> TERM + 1 idle); no cycle lost between IFG and preamble.
- Port 0 drops SRC_RDY for 2 cycles mid-frame: 2 words FE×8 TXC 0xFF, UNDERRUN pulses twice, remaining data then terminate follow normally.
- Port 1 offers non-SOP word while idle: DST_RDY[1]=1 for one cycle, DROP pulses, XGMII stays idle; following SOP frame is granted normally.
- RESET_N low for one cycle during DATA: TXD/TXC return to 07×8/0xFF immediately, GRANT=0; after release, pending SOP on port 0 yields preamble next cycle.
